// File: rtl/arc4_sched.sv
// rtl/arc4_sched.sv - ARC4 engine sequencer and single-port S RAM arbiter
// Optional per-phase watchdog compiled in with ARC4_WATCHDOG_EN.
module arc4_sched #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  output logic        done,
  output logic        err,
  input  logic [23:0] key,
  output logic [23:0] ksa_key,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  init_wrdata,
  input  logic [7:0]  ksa_wrdata,
  input  logic [7:0]  prga_wrdata,
  input  logic        init_wren,
  input  logic        ksa_wren,
  input  logic        prga_wren,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wrdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_rddata,
  output logic [7:0]  eng_rddata
);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_BUSY, S_WAIT, S_DONE, S_ERROR} state_t;
  typedef enum logic [1:0] {OWN_INIT, OWN_KSA, OWN_PRGA, OWN_NONE} owner_t;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("arc4_sched: TIMEOUT must be in 2..65535");
  end

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [1:0]  phase_q, phase_d;
  logic [23:0] key_q;
  logic        eng_rdy;
  logic        timeout;
  logic        accept;

  assign accept = en && (state_q == S_IDLE || state_q == S_ERROR);

  always_comb begin
    eng_rdy = 1'b1;
    case (phase_q)
      2'd0:    eng_rdy = init_rdy;
      2'd1:    eng_rdy = ksa_rdy;
      2'd2:    eng_rdy = prga_rdy;
      default: eng_rdy = 1'b1;
    endcase
  end

`ifdef ARC4_WATCHDOG_EN
  logic [15:0] wd_cnt_q;
  logic        err_q;

  // Trip one cycle early so the counter has reached TIMEOUT-1 as ERROR is entered.
  assign timeout = (state_q == S_BUSY || state_q == S_WAIT) &&
                   (wd_cnt_q == 16'(TIMEOUT - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_GO) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_BUSY || state_q == S_WAIT) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_d == S_ERROR && state_q != S_ERROR) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (en) begin
          state_d = S_GO;
          phase_d = 2'd0;
          owner_d = OWN_NONE;
        end
      end
      S_GO: begin
        owner_d = owner_t'(phase_q);
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (!eng_rdy) begin
          state_d = S_WAIT;
        end else if (timeout) begin
          state_d = S_ERROR;
          owner_d = OWN_NONE;
        end
      end
      S_WAIT: begin
        if (eng_rdy) begin
          owner_d = OWN_NONE;
          if (phase_q < 2'd2) begin
            phase_d = phase_q + 2'd1;
            state_d = S_GO;
          end else begin
            state_d = S_DONE;
          end
        end else if (timeout) begin
          state_d = S_ERROR;
          owner_d = OWN_NONE;
        end
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      owner_q <= OWN_NONE;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      owner_q <= owner_d;
      if (accept) key_q <= key;
    end
  end

  // Handshake outputs decode straight from state so reset removes them immediately.
  assign rdy     = (state_q == S_IDLE) || (state_q == S_ERROR);
  assign done    = (state_q == S_DONE);
  assign init_en = (state_q == S_GO) && (phase_q == 2'd0);
  assign ksa_en  = (state_q == S_GO) && (phase_q == 2'd1);
  assign prga_en = (state_q == S_GO) && (phase_q == 2'd2);
  assign ksa_key = key_q;

  always_comb begin
    mem_addr   = 8'h00;
    mem_wrdata = 8'h00;
    mem_wren   = 1'b0;
    case (owner_q)
      OWN_INIT: begin
        mem_addr   = init_addr;
        mem_wrdata = init_wrdata;
        mem_wren   = init_wren;
      end
      OWN_KSA: begin
        mem_addr   = ksa_addr;
        mem_wrdata = ksa_wrdata;
        mem_wren   = ksa_wren;
      end
      OWN_PRGA: begin
        mem_addr   = prga_addr;
        mem_wrdata = prga_wrdata;
        mem_wren   = prga_wren;
      end
      default: begin
        mem_addr   = 8'h00;
        mem_wrdata = 8'h00;
        mem_wren   = 1'b0;
      end
    endcase
  end

  assign eng_rddata = mem_rddata;

endmodule

// File: tb/tb_arc4_sched.sv
// tb/tb_arc4_sched.sv - directed bench for arc4_sched with behavioural engine models
// Watchdog checks follow ARC4_WATCHDOG_EN (TIMEOUT=64).
module tb_arc4_sched;

  logic        clk = 1'b0;
  logic        rst, en, done, rdy, err;
  logic [23:0] key, ksa_key;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr, ksa_addr, prga_addr;
  logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;
  logic [7:0]  mem_addr, mem_wrdata, mem_rddata, eng_rddata;
  logic        mem_wren;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arc4_sched #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done), .err(err),
    .key(key), .ksa_key(ksa_key),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
    .mem_rddata(mem_rddata), .eng_rddata(eng_rddata)
  );

  // Engine models: rdy low for len cycles after en; zl also drops rdy during the en cycle.
  int   init_len, ksa_len, prga_len;
  logic zl, hang;
  logic [15:0] ic, kc, pc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ic <= '0; kc <= '0; pc <= '0;
    end else begin
      if (init_en) ic <= 16'(init_len); else if (ic != 0) ic <= ic - 16'd1;
      if (ksa_en)  kc <= 16'(ksa_len);  else if (kc != 0) kc <= kc - 16'd1;
      if (prga_en) pc <= 16'(prga_len); else if (pc != 0) pc <= pc - 16'd1;
    end
  end

  assign init_rdy = (ic == 0) && !(zl && init_en);
  assign ksa_rdy  = (kc == 0) && !(zl && ksa_en);
  assign prga_rdy = (pc == 0) && !hang && !(zl && prga_en);

  int cyc = 0, n_init = 0, n_ksa = 0, n_prga = 0, n_done = 0;
  int t_init = 0, t_ksa = 0, t_prga = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (init_en) begin n_init = n_init + 1; t_init = cyc; end
    if (ksa_en)  begin n_ksa  = n_ksa + 1;  t_ksa  = cyc; end
    if (prga_en) begin n_prga = n_prga + 1; t_prga = cyc; end
    if (done) n_done = n_done + 1;
  end

  typedef struct packed {
    logic [7:0] ia, iw; logic ie;
    logic [7:0] ka, kw; logic ke;
    logic [7:0] pa, pw; logic pe;
    logic [7:0] rd;
    logic [7:0] xa, xw; logic xe;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic logic sel(input int id);
    case (id)
      0: return init_en;
      1: return ksa_en;
      2: return prga_en;
      3: return prga_rdy;
      4: return !prga_rdy;
      default: return done;
    endcase
  endfunction

  task automatic wait_on(input int id, input int budget, input string nm);
    int k;
    k = 0;
    do begin
      tick;
      k++;
    end while (!sel(id) && k < budget);
    check({nm, "_reached"}, 32'(sel(id)), 32'd1);
  endtask

  task automatic apply(input vec_t v);
    init_addr = v.ia; init_wrdata = v.iw; init_wren = v.ie;
    ksa_addr  = v.ka; ksa_wrdata  = v.kw; ksa_wren  = v.ke;
    prga_addr = v.pa; prga_wrdata = v.pw; prga_wren = v.pe;
    mem_rddata = v.rd;
  endtask

  task automatic check_vec(input string nm, input vec_t v);
    check({nm, "_addr"},  32'(mem_addr),   32'(v.xa));
    check({nm, "_wdata"}, 32'(mem_wrdata), 32'(v.xw));
    check({nm, "_wren"},  32'(mem_wren),   32'(v.xe));
    check({nm, "_rd"},    32'(eng_rddata), 32'(v.rd));
  endtask

  vec_t idle_v[3];
  vec_t ksa_v[3];
  vec_t zero_v;
  int   b_init, b_ksa, b_prga, b_done;

  task automatic snap;
    b_init = n_init; b_ksa = n_ksa; b_prga = n_prga; b_done = n_done;
  endtask

  task automatic start(input logic [23:0] k);
    key = k;
    en  = 1'b1;
    tick;
    en  = 1'b0;
  endtask

  initial begin
    idle_v[0] = '{8'h55, 8'h11, 1'b1, 8'hAA, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0};
    idle_v[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0};
    idle_v[2] = '{8'h01, 8'h02, 1'b0, 8'h03, 8'h04, 1'b0, 8'h05, 8'h06, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    ksa_v[0]  = '{8'h55, 8'h11, 1'b1, 8'hAA, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1, 8'hC3, 8'hAA, 8'h22, 1'b1};
    ksa_v[1]  = '{8'h55, 8'h11, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h77, 8'h88, 1'b1, 8'h00, 8'h0F, 8'hF0, 1'b0};
    ksa_v[2]  = '{8'h00, 8'h00, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h12, 8'h34, 1'b0, 8'h7E, 8'hFF, 8'h01, 1'b1};
    zero_v    = '0;

    rst = 1'b1; en = 1'b0; key = '0; zl = 1'b0; hang = 1'b0;
    init_len = 256; ksa_len = 768; prga_len = 1024;
    apply(zero_v);
    tick; tick;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
    check("rst_key", 32'(ksa_key), 32'd0);
    check("rst_mem", 32'({mem_addr, mem_wrdata, mem_wren}), 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 3; i++) begin
      apply(idle_v[i]);
      #1;
      check_vec($sformatf("idle%0d", i), idle_v[i]);
    end
    apply(zero_v);

    // Full run with long engines, arbitration and ignored en in the ksa phase.
    snap;
    start(24'h000318);
    check("acc_init_en", 32'(init_en), 32'd1);
    check("acc_rdy", 32'(rdy), 32'd0);
    wait_on(1, 400, "ksa_en");
    check("ksa_key1", 32'(ksa_key), 32'h000318);
    tick;
    for (int i = 0; i < 3; i++) begin
      apply(ksa_v[i]);
      #1;
      check_vec($sformatf("ksa%0d", i), ksa_v[i]);
      tick;
    end
    apply(zero_v);
    start(24'hFFFFFF);
    tick;
    check("busy_en_rdy", 32'(rdy), 32'd0);
    check("busy_en_key", 32'(ksa_key), 32'h000318);
    check("busy_en_init", 32'(n_init - b_init), 32'd1);
    wait_on(2, 900, "prga_en");
    wait_on(4, 10, "prga_busy");
    wait_on(3, 1200, "prga_rdy");
    check("m_done", 32'({done, rdy}), 32'b00);
    tick;
    check("m1_done", 32'({done, rdy}), 32'b10);
    tick;
    check("m2_done", 32'({done, rdy}), 32'b01);
    check("run1_pulses", 32'({8'(n_init - b_init), 8'(n_ksa - b_ksa), 8'(n_prga - b_prga), 8'(n_done - b_done)}),
          32'h01010101);
    check("run1_order", 32'(t_init < t_ksa && t_ksa < t_prga), 32'd1);
    check("run1_key", 32'(ksa_key), 32'h000318);

    // Asynchronous reset while ksa owns the port and writes.
    init_len = 8; ksa_len = 8; prga_len = 8;
    start(24'h123456);
    wait_on(1, 50, "ksa_en2");
    init_wren = 1'b1; init_addr = 8'h55; ksa_wren = 1'b1; ksa_addr = 8'hAA; ksa_wrdata = 8'h05;
    tick;
    check("pre_rst_wren", 32'({mem_wren, mem_addr}), 32'h1AA);
    #1 rst = 1'b1;
    #1;
    check("arst_mem", 32'({mem_wren, mem_addr, mem_wrdata}), 32'd0);
    check("arst_rdy", 32'(rdy), 32'd1);
    check("arst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
    tick;
    rst = 1'b0;
    apply(zero_v);
    tick;
    check("post_rst_key", 32'(ksa_key), 32'd0);
    snap;
    start(24'h000318);
    check("restart_init_en", 32'(init_en), 32'd1);
    wait_on(5, 200, "done2");
    check("run2_done", 32'(n_done - b_done), 32'd1);

    // Zero-latency rdy drop.
    zl = 1'b1; init_len = 3; ksa_len = 3; prga_len = 3;
    tick;
    snap;
    start(24'hABCDEF);
    wait_on(5, 200, "done3");
    repeat (5) tick;
    check("zl_done", 32'(n_done - b_done), 32'd1);
    check("zl_pulses", 32'((n_init - b_init) + (n_ksa - b_ksa) + (n_prga - b_prga)), 32'd3);
    check("zl_rdy", 32'(rdy), 32'd1);
    zl = 1'b0;

    // prga never reports busy/ready: watchdog or indefinite wait.
    hang = 1'b1; init_len = 4; ksa_len = 4; prga_len = 4;
    start(24'h000001);
    wait_on(2, 100, "hang_prga_en");
`ifdef ARC4_WATCHDOG_EN
    repeat (63) tick;
    check("wd_err_early", 32'(err), 32'd0);
    tick;
    check("wd_err", 32'({err, rdy}), 32'b11);
    snap;
    repeat (20) tick;
    check("wd_no_prga_en", 32'(n_prga - b_prga), 32'd0);
    check("wd_err_sticky", 32'(err), 32'd1);
    hang = 1'b0;
    start(24'h000002);
    check("wd_clear", 32'({err, init_en}), 32'b01);
    wait_on(5, 200, "done_wd");
`else
    repeat (200) tick;
    check("nowd_rdy", 32'(rdy), 32'd0);
    check("nowd_err", 32'(err), 32'd0);
    hang = 1'b0;
    wait_on(5, 50, "done_nowd");
`endif
    tick;
    check("final_rdy", 32'(rdy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
